// File: rtl/uart_if_param.sv
// Full-duplex UART with a majority-voted receiver, rx/tx FIFOs and sticky error flags.
// Optional parity bit when UART_PARITY_EN is defined (adds parity_odd / err_parity).
module uart_if_param #(
  parameter int FIFO_AW   = 3,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic             tx,
  input  logic [15:0]      baud_div,
  input  logic             rx_rden,
  output logic [7:0]       rx_rdata,
  output logic             rx_dvalid,
  output logic             rx_full,
  output logic [FIFO_AW:0] rx_count,
  input  logic             tx_wten,
  input  logic [7:0]       tx_wdata,
  output logic             tx_full,
  output logic             tx_busy,
  input  logic             err_clr,
`ifdef UART_PARITY_EN
  input  logic             parity_odd,
  output logic             err_parity,
`endif
  output logic             err_frame,
  output logic             err_overrun,
  output logic             err_underrun
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam logic [3:0] LAST_DBIT = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_SBIT = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  // rx front end
  logic       sync1_q, sync2_q;
  logic [4:0] taps_q;
  logic [2:0] ones;
  logic       maj, start_det;
  assign ones = 3'(taps_q[0]) + 3'(taps_q[1]) + 3'(taps_q[2]) + 3'(taps_q[3]) + 3'(taps_q[4]);
  assign maj = (ones >= 3'd3);
  assign start_det = taps_q[0] & ~sync2_q;

  // rx FSM
  state_e                 rx_st_q, rx_st_d;
  logic [15:0]            rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [3:0]             rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_sh_q, rx_sh_d;
  logic                   rx_tick, rx_wr, set_frame, set_rx_ovr;
`ifdef UART_PARITY_EN
  logic                   set_par, err_par_q, err_par_d, tx_par_q, tx_par_d;
`endif

  // FIFOs
  logic [DATA_BITS-1:0]   rxf_mem_q [DEPTH];
  logic [DATA_BITS-1:0]   txf_mem_q [DEPTH];
  logic [FIFO_AW-1:0]     rxf_wp_q, rxf_wp_d, rxf_rp_q, rxf_rp_d;
  logic [FIFO_AW-1:0]     txf_wp_q, txf_wp_d, txf_rp_q, txf_rp_d;
  logic [CW-1:0]          rxf_cnt_q, rxf_cnt_d, txf_cnt_q, txf_cnt_d;
  logic                   rxf_push, rxf_pop, txf_push, txf_pop;
  logic [DATA_BITS-1:0]   txf_head;

  // tx FSM
  state_e                 tx_st_q, tx_st_d;
  logic [15:0]            tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [3:0]             tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]   tx_sh_q, tx_sh_d;
  logic                   tx_q, tx_d, tx_tick, tx_load;

  logic err_frame_q, err_frame_d, err_ovr_q, err_ovr_d, err_und_q, err_und_d;

  assign rx_tick = (rx_cnt_q <= 16'd1);
  assign tx_tick = (tx_cnt_q <= 16'd1);

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = (rx_cnt_q != 16'd0) ? rx_cnt_q - 16'd1 : 16'd0;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_wr      = 1'b0;
    set_frame  = 1'b0;
    set_rx_ovr = 1'b0;
`ifdef UART_PARITY_EN
    set_par    = 1'b0;
`endif
    case (rx_st_q)
      S_IDLE: if (start_det) begin
        rx_st_d  = S_START;
        rx_cnt_d = baud_div >> 1;
        rx_div_d = baud_div;
      end
      S_START: if (rx_tick) begin
        // a start bit that is high again at mid-bit was a glitch
        if (!maj) begin
          rx_st_d  = S_DATA;
          rx_cnt_d = rx_div_q;
          rx_bit_d = 4'd0;
        end else begin
          rx_st_d = S_IDLE;
        end
      end
      S_DATA: if (rx_tick) begin
        rx_sh_d  = {maj, rx_sh_q[DATA_BITS-1:1]};
        rx_cnt_d = rx_div_q;
        rx_bit_d = rx_bit_q + 4'd1;
`ifdef UART_PARITY_EN
        if (rx_bit_q == LAST_DBIT) rx_st_d = S_PAR;
`else
        if (rx_bit_q == LAST_DBIT) rx_st_d = S_STOP;
`endif
      end
`ifdef UART_PARITY_EN
      S_PAR: if (rx_tick) begin
        set_par  = ((^rx_sh_q) ^ maj) != parity_odd;
        rx_st_d  = S_STOP;
        rx_cnt_d = rx_div_q;
      end
`endif
      S_STOP: if (rx_tick) begin
        rx_st_d = S_IDLE;
        if (!maj)        set_frame  = 1'b1;
        else if (rx_full) set_rx_ovr = 1'b1;
        else             rx_wr      = 1'b1;
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  assign rxf_push  = rx_wr;
  assign rxf_pop   = rx_rden & rx_dvalid;
  assign rxf_wp_d  = rxf_wp_q + FIFO_AW'(rxf_push);
  assign rxf_rp_d  = rxf_rp_q + FIFO_AW'(rxf_pop);
  assign rxf_cnt_d = rxf_cnt_q + CW'(rxf_push) - CW'(rxf_pop);
  assign rx_dvalid = (rxf_cnt_q != '0);
  assign rx_full   = (rxf_cnt_q == CW'(DEPTH));
  assign rx_count  = rxf_cnt_q;

  always_comb begin
    rx_rdata = '0;
    rx_rdata[DATA_BITS-1:0] = rxf_mem_q[rxf_rp_q];
  end

  assign txf_push  = tx_wten & ~tx_full;
  assign txf_head  = txf_mem_q[txf_rp_q];
  assign txf_wp_d  = txf_wp_q + FIFO_AW'(txf_push);
  assign txf_rp_d  = txf_rp_q + FIFO_AW'(txf_pop);
  assign txf_cnt_d = txf_cnt_q + CW'(txf_push) - CW'(txf_pop);
  assign tx_full   = (txf_cnt_q == CW'(DEPTH));
  assign tx_busy   = (tx_st_q != S_IDLE) || (txf_cnt_q != '0);
  assign tx        = tx_q;

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = (tx_cnt_q != 16'd0) ? tx_cnt_q - 16'd1 : 16'd0;
    tx_div_d = tx_div_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_d     = tx_q;
    tx_load  = 1'b0;
    txf_pop  = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d = tx_par_q;
`endif
    case (tx_st_q)
      S_IDLE: if (txf_cnt_q != '0) tx_load = 1'b1;
      S_START: if (tx_tick) begin
        tx_st_d  = S_DATA;
        tx_cnt_d = tx_div_q;
        tx_bit_d = 4'd0;
        tx_d     = tx_sh_q[0];
      end
      S_DATA: if (tx_tick) begin
        tx_cnt_d = tx_div_q;
        if (tx_bit_q == LAST_DBIT) begin
`ifdef UART_PARITY_EN
          tx_st_d = S_PAR;
          tx_d    = tx_par_q;
`else
          tx_st_d  = S_STOP;
          tx_d     = 1'b1;
          tx_bit_d = 4'd0;
`endif
        end else begin
          tx_sh_d  = tx_sh_q >> 1;
          tx_d     = tx_sh_q[1];
          tx_bit_d = tx_bit_q + 4'd1;
        end
      end
`ifdef UART_PARITY_EN
      S_PAR: if (tx_tick) begin
        tx_st_d  = S_STOP;
        tx_d     = 1'b1;
        tx_cnt_d = tx_div_q;
        tx_bit_d = 4'd0;
      end
`endif
      S_STOP: if (tx_tick) begin
        if (tx_bit_q == LAST_SBIT) begin
          // chain straight into the next start bit when more data is queued
          if (txf_cnt_q != '0) tx_load = 1'b1;
          else begin
            tx_st_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          tx_bit_d = tx_bit_q + 4'd1;
          tx_cnt_d = tx_div_q;
        end
      end
      default: begin
        tx_st_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (tx_load) begin
      txf_pop  = 1'b1;
      tx_sh_d  = txf_head;
      tx_div_d = baud_div;
      tx_cnt_d = baud_div;
      tx_st_d  = S_START;
      tx_d     = 1'b0;
`ifdef UART_PARITY_EN
      tx_par_d = (^txf_head) ^ parity_odd;
`endif
    end
  end

  // set-dominant sticky flags
  assign err_frame_d = set_frame | (err_frame_q & ~err_clr);
  assign err_ovr_d   = set_rx_ovr | (tx_wten & tx_full) | (err_ovr_q & ~err_clr);
  assign err_und_d   = (rx_rden & ~rx_dvalid) | (err_und_q & ~err_clr);
  assign err_frame    = err_frame_q;
  assign err_overrun  = err_ovr_q;
  assign err_underrun = err_und_q;
`ifdef UART_PARITY_EN
  assign err_par_d  = set_par | (err_par_q & ~err_clr);
  assign err_parity = err_par_q;
`endif

  always_ff @(posedge clk) begin
    if (rxf_push) rxf_mem_q[rxf_wp_q] <= rx_sh_q;
    if (txf_push) txf_mem_q[txf_wp_q] <= tx_wdata[DATA_BITS-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      taps_q      <= '1;
      rx_st_q     <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_div_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rxf_wp_q    <= '0;
      rxf_rp_q    <= '0;
      rxf_cnt_q   <= '0;
      txf_wp_q    <= '0;
      txf_rp_q    <= '0;
      txf_cnt_q   <= '0;
      tx_st_q     <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_div_q    <= '0;
      tx_bit_q    <= '0;
      tx_sh_q     <= '0;
      tx_q        <= 1'b1;
      err_frame_q <= 1'b0;
      err_ovr_q   <= 1'b0;
      err_und_q   <= 1'b0;
`ifdef UART_PARITY_EN
      err_par_q   <= 1'b0;
      tx_par_q    <= 1'b0;
`endif
    end else begin
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      taps_q      <= {taps_q[3:0], sync2_q};
      rx_st_q     <= rx_st_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_div_q    <= rx_div_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      rxf_wp_q    <= rxf_wp_d;
      rxf_rp_q    <= rxf_rp_d;
      rxf_cnt_q   <= rxf_cnt_d;
      txf_wp_q    <= txf_wp_d;
      txf_rp_q    <= txf_rp_d;
      txf_cnt_q   <= txf_cnt_d;
      tx_st_q     <= tx_st_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      tx_bit_q    <= tx_bit_d;
      tx_sh_q     <= tx_sh_d;
      tx_q        <= tx_d;
      err_frame_q <= err_frame_d;
      err_ovr_q   <= err_ovr_d;
      err_und_q   <= err_und_d;
`ifdef UART_PARITY_EN
      err_par_q   <= err_par_d;
      tx_par_q    <= tx_par_d;
`endif
    end
  end
endmodule
